chip_chamber_sequencer: RTL and testbench



---
 rtl/chip_chamber_sequencer_pkg.sv | 76 +++++++
 rtl/chip_chamber_sequencer_if.sv | 13 +
 rtl/chip_chamber_sequencer_pump.sv | 56 +++++
 rtl/chip_chamber_sequencer.sv | 175 +++++++++++++++++
 tb/tb_chip_chamber_sequencer.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/chip_chamber_sequencer_pkg.sv
// Shared types and constants for the ChIP ring-chamber valve sequencer:
// phase codes, valve-vector layout, per-phase open masks and the pump pattern.
package chip_ctrl_pkg;

    typedef enum logic [2:0] {
        PH_IDLE    = 3'd0,
        PH_LOAD    = 3'd1,
        PH_BEAD    = 3'd2,
        PH_MIX     = 3'd3,
        PH_WASH    = 3'd4,
        PH_COLLECT = 3'd5,
        PH_GUARD   = 3'd6,
        PH_ABORT   = 3'd7
    } phase_e;

    localparam int unsigned V_RING_IN  = 0;
    localparam int unsigned V_RING_OUT = 1;
    localparam int unsigned V_SIEVE    = 2;
    localparam int unsigned V_COLLECT  = 3;
    localparam int unsigned V_INLET    = 4;
    localparam int unsigned V_OUTLET   = 5;
    localparam int unsigned V_BEAD     = 6;
    localparam int unsigned V_PUMP1    = 7;
    localparam int unsigned V_PUMP2    = 8;
    localparam int unsigned V_PUMP3    = 9;

    // Valve air: 1 = pressurized/closed, 0 = open
    localparam logic [9:0] VALVE_ALL_CLOSED = '1;

    localparam logic [9:0] OPEN_LOAD    = (10'b1 << V_INLET) | (10'b1 << V_PUMP2) | (10'b1 << V_OUTLET);
    localparam logic [9:0] OPEN_BEAD    = (10'b1 << V_BEAD)  | (10'b1 << V_PUMP2) | (10'b1 << V_OUTLET);
    localparam logic [9:0] OPEN_WASH    = (10'b1 << V_INLET) | (10'b1 << V_PUMP1) |
                                          (10'b1 << V_RING_OUT) | (10'b1 << V_COLLECT);
    localparam logic [9:0] OPEN_COLLECT = (10'b1 << V_RING_IN) | (10'b1 << V_RING_OUT) |
                                          (10'b1 << V_SIEVE)   | (10'b1 << V_COLLECT);

    // Six-step peristaltic pattern as {pump1,pump2,pump3}
    function automatic logic [2:0] pump_pattern(input logic [2:0] step);
        logic [2:0] pat;
        pat = 3'b111;
        case (step)
            3'd0:    pat = 3'b011;
            3'd1:    pat = 3'b001;
            3'd2:    pat = 3'b101;
            3'd3:    pat = 3'b100;
            3'd4:    pat = 3'b110;
            3'd5:    pat = 3'b010;
            default: pat = 3'b111;
        endcase
        return pat;
    endfunction

    function automatic logic [9:0] valve_map(input phase_e ph, input logic [2:0] pat);
        logic [9:0] v;
        v = VALVE_ALL_CLOSED;
        case (ph)
            PH_LOAD: v = ~OPEN_LOAD;
            PH_BEAD: v = ~OPEN_BEAD;
            PH_WASH: v = ~OPEN_WASH;
            PH_MIX: begin
                v[V_PUMP1] = pat[2];
                v[V_PUMP2] = pat[1];
                v[V_PUMP3] = pat[0];
            end
            PH_COLLECT: begin
                v = ~OPEN_COLLECT;
                v[V_PUMP1] = pat[2];
                v[V_PUMP2] = pat[1];
                v[V_PUMP3] = pat[0];
            end
            default: v = VALVE_ALL_CLOSED;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/chip_chamber_sequencer_if.sv
// Host command/status bundle of the chamber sequencer.
interface chip_chamber_sequencer_if;
    logic       start;
    logic       abort;
    logic [7:0] mix_rot;
    logic       busy;
    logic       done;
    logic       aborted;
    logic [2:0] phase;

    modport master (output start, abort, mix_rot, input busy, done, aborted, phase);
    modport slave  (input start, abort, mix_rot, output busy, done, aborted, phase);
endinterface

// File: rtl/chip_chamber_sequencer_pump.sv
// Peristaltic pump pattern generator: steps through the 6-entry pattern and
// flags the last cycle of the target rotation count.
module peristaltic_pump_gen
    import chip_ctrl_pkg::*;
#(
    parameter int unsigned PUMP_STEP_CYC = 1000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic        clear,
    input  logic [10:0] rot_target,
    output logic [2:0]  pattern,
    output logic        rot_done
);

    localparam logic [15:0] STEP_LAST = 16'(PUMP_STEP_CYC - 1);

    logic [15:0] step_cyc;
    logic [2:0]  step_idx;
    logic [10:0] rot_cnt;
    logic        step_end;
    logic        rot_end;

    always_comb begin
        step_end = (step_cyc == STEP_LAST);
        rot_end  = step_end && (step_idx == 3'd5);
        pattern  = pump_pattern(step_idx);
        rot_done = enable && !clear && rot_end && (rot_cnt == rot_target - 11'd1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            step_cyc <= '0;
            step_idx <= '0;
            rot_cnt  <= '0;
        end else if (clear) begin
            step_cyc <= '0;
            step_idx <= '0;
            rot_cnt  <= '0;
        end else if (enable) begin
            if (step_end) begin
                step_cyc <= '0;
                if (step_idx == 3'd5) begin
                    step_idx <= '0;
                    rot_cnt  <= rot_cnt + 11'd1;
                end else begin
                    step_idx <= step_idx + 3'd1;
                end
            end else begin
                step_cyc <= step_cyc + 16'd1;
            end
        end
    end

endmodule

// File: rtl/chip_chamber_sequencer.sv
// ChIP ring-chamber sequencer: runs LOAD/BEAD/MIX/WASH/COLLECT with one-cycle
// all-closed guards between phases and drives every valve air line.
module chip_chamber_sequencer
    import chip_ctrl_pkg::*;
#(
    parameter int unsigned PUMP_STEP_CYC = 1000,
    parameter int unsigned LOAD_CYC      = 20000,
    parameter int unsigned BEAD_CYC      = 20000,
    parameter int unsigned WASH_CYC      = 50000,
    parameter int unsigned COLLECT_ROT   = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    chip_chamber_sequencer_if.slave  cmd,
    output logic                     ring_in_ctrl,
    output logic                     ring_out_ctrl,
    output logic                     sieve_ctrl,
    output logic                     collect_ctrl,
    output logic                     inlet_ctrl,
    output logic                     outlet_ctrl,
    output logic                     bead_ctrl,
    output logic                     pump1,
    output logic                     pump2,
    output logic                     pump3
);

    localparam logic [31:0] LOAD_LAST = 32'(LOAD_CYC - 1);
    localparam logic [31:0] BEAD_LAST = 32'(BEAD_CYC - 1);
    localparam logic [31:0] WASH_LAST = 32'(WASH_CYC - 1);
    localparam logic [10:0] COLL_ROT  = 11'(COLLECT_ROT);

    phase_e      state, state_d;
    phase_e      after_guard, after_guard_d;
    logic [31:0] phase_cnt, phase_cnt_d;
    logic [7:0]  mix_rot_q, mix_rot_d;
    logic        done_s, done_d;

    logic        pump_en;
    logic [10:0] rot_target;
    logic [2:0]  pump_pat;
    logic        rot_done;

    logic [9:0]  valve_q;
    logic [2:0]  phase_q;
    logic        busy_q;
    logic        done_q;
    logic        aborted_q;

    always_comb begin
        pump_en    = (state == PH_MIX) || (state == PH_COLLECT);
        rot_target = (state == PH_MIX) ? {3'b000, mix_rot_q} : COLL_ROT;
    end

    peristaltic_pump_gen #(
        .PUMP_STEP_CYC (PUMP_STEP_CYC)
    ) u_pump (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (pump_en),
        .clear      (!pump_en),
        .rot_target (rot_target),
        .pattern    (pump_pat),
        .rot_done   (rot_done)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= PH_IDLE;
            after_guard <= PH_IDLE;
            phase_cnt   <= '0;
            mix_rot_q   <= '0;
            done_s      <= 1'b0;
        end else begin
            state       <= state_d;
            after_guard <= after_guard_d;
            phase_cnt   <= phase_cnt_d;
            mix_rot_q   <= mix_rot_d;
            done_s      <= done_d;
        end
    end

    always_comb begin
        state_d       = state;
        after_guard_d = after_guard;
        phase_cnt_d   = phase_cnt + 32'd1;
        mix_rot_d     = mix_rot_q;
        done_d        = 1'b0;
        case (state)
            PH_IDLE: begin
                if (cmd.start && !cmd.abort) begin
                    state_d   = PH_LOAD;
                    mix_rot_d = cmd.mix_rot;
                end
            end
            PH_LOAD: begin
                if (phase_cnt == LOAD_LAST) begin
                    state_d       = PH_GUARD;
                    after_guard_d = PH_BEAD;
                end
            end
            PH_BEAD: begin
                if (phase_cnt == BEAD_LAST) begin
                    state_d       = PH_GUARD;
                    after_guard_d = (mix_rot_q == 8'd0) ? PH_WASH : PH_MIX;
                end
            end
            PH_MIX: begin
                if (rot_done) begin
                    state_d       = PH_GUARD;
                    after_guard_d = PH_WASH;
                end
            end
            PH_WASH: begin
                if (phase_cnt == WASH_LAST) begin
                    state_d       = PH_GUARD;
                    after_guard_d = PH_COLLECT;
                end
            end
            PH_COLLECT: begin
                if (rot_done) begin
                    state_d       = PH_GUARD;
                    after_guard_d = PH_IDLE;
                end
            end
            PH_GUARD: begin
                state_d = after_guard;
                done_d  = (after_guard == PH_IDLE);
            end
            PH_ABORT: state_d = PH_IDLE;
            default:  state_d = PH_IDLE;
        endcase
        // Abort overrides any transition, including the final guard's done
        if (cmd.abort && (state != PH_IDLE) && (state != PH_ABORT)) begin
            state_d = PH_ABORT;
            done_d  = 1'b0;
        end
        if ((state_d != state) || (state == PH_IDLE)) begin
            phase_cnt_d = '0;
        end
    end

    // Outputs are a registered image of the current state, one cycle behind it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valve_q   <= VALVE_ALL_CLOSED;
            phase_q   <= PH_IDLE;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            aborted_q <= 1'b0;
        end else begin
            valve_q   <= valve_map(state, pump_pat);
            phase_q   <= state;
            busy_q    <= (state != PH_IDLE);
            done_q    <= done_s;
            aborted_q <= (state == PH_ABORT);
        end
    end

    assign cmd.busy    = busy_q;
    assign cmd.done    = done_q;
    assign cmd.aborted = aborted_q;
    assign cmd.phase   = phase_q;

    assign ring_in_ctrl  = valve_q[V_RING_IN];
    assign ring_out_ctrl = valve_q[V_RING_OUT];
    assign sieve_ctrl    = valve_q[V_SIEVE];
    assign collect_ctrl  = valve_q[V_COLLECT];
    assign inlet_ctrl    = valve_q[V_INLET];
    assign outlet_ctrl   = valve_q[V_OUTLET];
    assign bead_ctrl     = valve_q[V_BEAD];
    assign pump1         = valve_q[V_PUMP1];
    assign pump2         = valve_q[V_PUMP2];
    assign pump3         = valve_q[V_PUMP3];

endmodule

// File: tb/tb_chip_chamber_sequencer.sv
// Scoreboard bench: stimulus queues the expected run-length trace of the
// output vector; the monitor pops a record on every output change.
module tb_chip_chamber_sequencer;

    logic clk;
    logic rst_n;

    chip_chamber_sequencer_if cmd();

    logic ring_in_ctrl, ring_out_ctrl, sieve_ctrl, collect_ctrl, inlet_ctrl;
    logic outlet_ctrl, bead_ctrl, pump1, pump2, pump3;

    chip_chamber_sequencer #(
        .PUMP_STEP_CYC (2),
        .LOAD_CYC      (5),
        .BEAD_CYC      (5),
        .WASH_CYC      (5),
        .COLLECT_ROT   (1)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .cmd           (cmd),
        .ring_in_ctrl  (ring_in_ctrl),
        .ring_out_ctrl (ring_out_ctrl),
        .sieve_ctrl    (sieve_ctrl),
        .collect_ctrl  (collect_ctrl),
        .inlet_ctrl    (inlet_ctrl),
        .outlet_ctrl   (outlet_ctrl),
        .bead_ctrl     (bead_ctrl),
        .pump1         (pump1),
        .pump2         (pump2),
        .pump3         (pump3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Valve order: ring_in ring_out sieve collect inlet outlet bead pump1 pump2 pump3
    localparam logic [9:0] V_CLOSED = 10'b1111111111;
    localparam logic [9:0] V_LOAD   = 10'b1111001101;
    localparam logic [9:0] V_BEAD   = 10'b1111100101;
    localparam logic [9:0] V_WASH   = 10'b1010011011;
    localparam logic [6:0] B_MIX    = 7'b1111111;
    localparam logic [6:0] B_COLL   = 7'b0000111;

    logic [2:0] pat [6] = '{3'b011, 3'b001, 3'b101, 3'b100, 3'b110, 3'b010};

    typedef struct {
        logic [15:0] vec;
        int          len;
    } rec_t;

    rec_t q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic push(input logic [2:0] ph, input logic b, input logic d, input logic a,
                        input logic [9:0] v, input int len);
        rec_t r;
        r.vec = {ph, b, d, a, v};
        r.len = len;
        q.push_back(r);
    endtask

    task automatic push_pump(input logic [2:0] ph, input logic [6:0] base, input int rots);
        for (int r = 0; r < rots; r++)
            for (int s = 0; s < 6; s++)
                push(ph, 1'b1, 1'b0, 1'b0, {base, pat[s]}, 2);
    endtask

    task automatic push_guard();
        push(3'd6, 1'b1, 1'b0, 1'b0, V_CLOSED, 1);
    endtask

    task automatic push_head();
        push(3'd1, 1'b1, 1'b0, 1'b0, V_LOAD, 5);
        push_guard();
        push(3'd2, 1'b1, 1'b0, 1'b0, V_BEAD, 5);
        push_guard();
    endtask

    task automatic push_prog(input int mr);
        push_head();
        if (mr > 0) begin
            push_pump(3'd3, B_MIX, mr);
            push_guard();
        end
        push(3'd4, 1'b1, 1'b0, 1'b0, V_WASH, 5);
        push_guard();
        push_pump(3'd5, B_COLL, 1);
        push_guard();
        push(3'd0, 1'b0, 1'b1, 1'b0, V_CLOSED, 1);
        push(3'd0, 1'b0, 1'b0, 1'b0, V_CLOSED, 0);
    endtask

    task automatic go(input logic [7:0] mr);
        @(negedge clk);
        cmd.start   = 1'b1;
        cmd.mix_rot = mr;
        @(negedge clk);
        cmd.start   = 1'b0;
    endtask

    // Monitor: a record's len of 0 means its hold time is not checked
    logic [15:0] cur;
    logic [15:0] smp;
    int          run     = 0;
    int          rec_len = 0;
    bit          first   = 1'b1;
    bit          have    = 1'b0;
    bit          mon_on  = 1'b0;
    rec_t        rr;

    always @(negedge clk) begin
        if (mon_on) begin
            smp = {cmd.phase, cmd.busy, cmd.done, cmd.aborted,
                   ring_in_ctrl, ring_out_ctrl, sieve_ctrl, collect_ctrl, inlet_ctrl,
                   outlet_ctrl, bead_ctrl, pump1, pump2, pump3};
            if (first || smp != cur) begin
                if (!first && have && rec_len != 0) begin
                    checks++;
                    if (run != rec_len) begin
                        errors++;
                        $display("FAIL hold_len: vec %h held %0d cycles, expected %0d at %0t",
                                 cur, run, rec_len, $time);
                    end
                end
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    have = 1'b0;
                    $display("FAIL unexpected_output: got %h with empty scoreboard at %0t", smp, $time);
                end else begin
                    rr = q.pop_front();
                    checks++;
                    if (smp !== rr.vec) begin
                        errors++;
                        $display("FAIL output_vec: got %h expected %h at %0t", smp, rr.vec, $time);
                    end
                    rec_len = rr.len;
                    have    = 1'b1;
                end
                cur   = smp;
                run   = 1;
                first = 1'b0;
            end else begin
                run++;
            end
        end
    end

    initial begin
        rst_n       = 1'b1;
        cmd.start   = 1'b0;
        cmd.abort   = 1'b0;
        cmd.mix_rot = 8'd0;
        push(3'd0, 1'b0, 1'b0, 1'b0, V_CLOSED, 0);
        mon_on = 1'b1;
        #1 rst_n = 1'b0;
        #20 rst_n = 1'b1;
        repeat (100) @(negedge clk);

        // Full program, mix_rot=2; mix_rot changed and start re-pulsed mid-WASH
        push_prog(2);
        go(8'd2);
        cmd.mix_rot = 8'd7;
        repeat (38) @(negedge clk);
        cmd.start   = 1'b1;
        cmd.mix_rot = 8'd3;
        @(negedge clk);
        cmd.start   = 1'b0;
        repeat (70) @(negedge clk);

        // mix_rot=0 skips MIX and its guard
        push_prog(0);
        go(8'd0);
        repeat (50) @(negedge clk);

        // Abort sampled while MIX shows step 3
        push_head();
        for (int s = 0; s < 3; s++)
            push(3'd3, 1'b1, 1'b0, 1'b0, {B_MIX, pat[s]}, 2);
        push(3'd3, 1'b1, 1'b0, 1'b0, {B_MIX, pat[3]}, 1);
        push(3'd7, 1'b1, 1'b0, 1'b1, V_CLOSED, 1);
        push(3'd0, 1'b0, 1'b0, 1'b0, V_CLOSED, 0);
        go(8'd2);
        repeat (18) @(negedge clk);
        cmd.abort = 1'b1;
        @(negedge clk);
        cmd.abort = 1'b0;
        repeat (10) @(negedge clk);

        // start and abort together in IDLE: nothing may change
        @(negedge clk);
        cmd.start = 1'b1;
        cmd.abort = 1'b1;
        @(negedge clk);
        cmd.start = 1'b0;
        cmd.abort = 1'b0;
        repeat (10) @(negedge clk);

        // Reset pulse between clock edges during COLLECT step 1
        push_head();
        push_pump(3'd3, B_MIX, 2);
        push_guard();
        push(3'd4, 1'b1, 1'b0, 1'b0, V_WASH, 5);
        push_guard();
        push(3'd5, 1'b1, 1'b0, 1'b0, {B_COLL, pat[0]}, 2);
        push(3'd5, 1'b1, 1'b0, 1'b0, {B_COLL, pat[1]}, 1);
        push(3'd0, 1'b0, 1'b0, 1'b0, V_CLOSED, 0);
        go(8'd2);
        repeat (46) @(negedge clk);
        #1 rst_n = 1'b0;
        #1 rst_n = 1'b1;
        repeat (5) @(negedge clk);

        // Fresh program after reset
        push_prog(1);
        go(8'd1);
        repeat (60) @(negedge clk);

        mon_on = 1'b0;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL trace_leftover: %0d records left, expected 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
